// File: rtl/uartb_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uartb_tx_arbiter
// Shares a single UARTB transmitter between NREQ byte-stream requesters.
// Round-robin selection, one write strobe per byte, waits for the core's
// busy flag to rise and fall before the next byte is taken. A packet (bytes
// up to req_last) holds the grant. A watchdog flags a core that never
// acknowledges a write with tx_busy.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   req_valid    per-channel byte pending
//   req_data     per-channel byte, channel i at [8i+7:8i]
//   req_last     per-channel end-of-packet marker
//   req_ready    one-hot accept pulse (IDLE only, combinational)
//   grant        one-hot current owner, 0 when unowned
//   tx_data      byte to UART core, held from tx_wr until next accept
//   tx_wr        one-cycle write strobe to UART core
//   tx_busy      UART core serialising a character
//   active       high whenever the sequencer is not IDLE
//   err_timeout  sticky: tx_busy did not rise within BUSY_TO cycles
//   err_clr      clears err_timeout (a coincident timeout wins)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | pick a candidate; accept when the core is not busy
// STROBE    | drive tx_wr for one cycle, arm the ack watchdog
// WAIT_ACK  | wait for tx_busy to rise; watchdog expiry returns to IDLE
// WAIT_DONE | wait for tx_busy to fall; release grant unless packet-locked
// ----------------------------------------------------------------------------
module uartb_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int BUSY_TO = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   grant,
   output logic [7:0]        tx_data,
   output logic              tx_wr,
   input  logic              tx_busy,
   output logic              active,
   output logic              err_timeout,
   input  logic              err_clr
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      STROBE    = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [IW-1:0]   ptr;
   logic            lock;
   logic [7:0]      cnt;

   logic            cand_found;
   logic [IW-1:0]   cand_idx;
   logic [7:0]      cand_data;
   logic            cand_last;
   logic [NREQ-1:0] cand_onehot;
   logic            accept;
   logic            ack_expired;

   // Candidate search. The pointer holds the last owner, so while locked it
   // doubles as the owner index. Unlocked, scan from ptr+NREQ down to ptr+1
   // so the nearest valid channel after the pointer is the last one written.
   always_comb begin
      int j;
      j          = 0;
      cand_found = 1'b0;
      cand_idx   = '0;
      if (lock) begin
         cand_found = req_valid[ptr];
         cand_idx   = ptr;
      end else begin
         for (int k = NREQ; k >= 1; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
               j = j - NREQ;
            end
            if (req_valid[IW'(j)]) begin
               cand_found = 1'b1;
               cand_idx   = IW'(j);
            end
         end
      end
   end

   always_comb begin
      cand_data = '0;
      cand_last = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (cand_idx == IW'(i)) begin
            cand_data = req_data[8*i +: 8];
            cand_last = req_last[i];
         end
      end
   end

   assign cand_onehot = NREQ'(1) << cand_idx;
   assign accept      = (state == IDLE) && cand_found && !tx_busy;

   // Watchdog is a down-counter armed in STROBE; reaching zero in WAIT_ACK
   // without busy lands err_timeout exactly BUSY_TO cycles after the strobe.
   assign ack_expired = (state == WAIT_ACK) && !tx_busy && (cnt == 8'd0);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = STROBE;
            end
         end
         STROBE: begin
            state_nxt = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (tx_busy) begin
               state_nxt = WAIT_DONE;
            end else if (cnt == 8'd0) begin
               state_nxt = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      req_ready = '0;
      tx_wr     = 1'b0;
      active    = 1'b0;
      if (accept) begin
         req_ready = cand_onehot;
      end
      if (state == STROBE) begin
         tx_wr = 1'b1;
      end
      if (state != IDLE) begin
         active = 1'b1;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_data     <= '0;
         grant       <= '0;
         ptr         <= IW'(NREQ-1);
         lock        <= 1'b0;
         cnt         <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (err_clr) begin
            err_timeout <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  tx_data <= cand_data;
                  grant   <= cand_onehot;
                  ptr     <= cand_idx;
                  lock    <= ~cand_last;
               end
            end
            STROBE: begin
               cnt <= 8'(BUSY_TO - 2);
            end
            WAIT_ACK: begin
               if (ack_expired) begin
                  err_timeout <= 1'b1;
                  lock        <= 1'b0;
                  grant       <= '0;
               end else if (!tx_busy) begin
                  cnt <= cnt - 8'd1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy && !lock) begin
                  grant <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uartb_tx_arbiter.sv
module tb_uartb_tx_arbiter;

   localparam int NREQ    = 4;
   localparam int BUSY_TO = 16;

   logic              clk;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   grant;
   logic [7:0]        tx_data;
   logic              tx_wr;
   logic              tx_busy;
   logic              active;
   logic              err_timeout;
   logic              err_clr;

   int passed;
   int total;

   uartb_tx_arbiter #(
      .NREQ    (NREQ),
      .BUSY_TO (BUSY_TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .grant       (grant),
      .tx_data     (tx_data),
      .tx_wr       (tx_wr),
      .tx_busy     (tx_busy),
      .active      (active),
      .err_timeout (err_timeout),
      .err_clr     (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] oh(input int ch);
      logic [3:0] v;
      v     = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic v, input logic [7:0] d, input logic l);
      req_valid[ch]      = v;
      req_data[8*ch +: 8] = d;
      req_last[ch]       = l;
   endtask

   // One byte through the sequencer with a core that raises busy two cycles
   // after tx_wr and holds it for ten cycles. Entered in accept cycle T with
   // inputs already applied; returns in cycle T+14 (IDLE again).
   task automatic xfer(input string tag, input int ch, input logic [7:0] d, input logic [3:0] g_after);
      #1;
      chk({tag, ":ready"}, 8'(req_ready), 8'(oh(ch)));
      chk({tag, ":idle"}, 8'(active), 8'd0);
      cyc();
      chk({tag, ":wr"}, 8'(tx_wr), 8'd1);
      chk({tag, ":data"}, tx_data, d);
      chk({tag, ":grant"}, 8'(grant), 8'(oh(ch)));
      chk({tag, ":ready_off"}, 8'(req_ready), 8'd0);
      cyc();
      chk({tag, ":wr_once"}, 8'(tx_wr), 8'd0);
      cyc();
      tx_busy = 1'b1;
      repeat (9) cyc();
      cyc();
      tx_busy = 1'b0;
      #1;
      chk({tag, ":grant_busy"}, 8'(grant), 8'(oh(ch)));
      chk({tag, ":no_rewr"}, 8'(tx_wr), 8'd0);
      chk({tag, ":active"}, 8'(active), 8'd1);
      cyc();
      chk({tag, ":done_idle"}, 8'(active), 8'd0);
      chk({tag, ":grant_after"}, 8'(grant), 8'(g_after));
   endtask

   initial begin
      passed    = 0;
      total     = 0;
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_busy   = 1'b0;
      err_clr   = 1'b0;

      // Reset state
      repeat (2) cyc();
      chk("rst:grant", 8'(grant), 8'd0);
      chk("rst:wr", 8'(tx_wr), 8'd0);
      chk("rst:data", tx_data, 8'd0);
      chk("rst:active", 8'(active), 8'd0);
      chk("rst:err", 8'(err_timeout), 8'd0);
      reset = 1'b0;

      // Single byte
      cyc();
      set_ch(0, 1'b1, 8'h55, 1'b1);
      xfer("single", 0, 8'h55, 4'b0000);
      req_valid = '0;

      // Round robin from a fresh pointer
      reset = 1'b1;
      #2;
      reset = 1'b0;
      cyc();
      set_ch(0, 1'b1, 8'hA0, 1'b1);
      set_ch(1, 1'b1, 8'hA1, 1'b1);
      set_ch(2, 1'b1, 8'hA2, 1'b1);
      set_ch(3, 1'b1, 8'hA3, 1'b1);
      xfer("rr0", 0, 8'hA0, 4'b0000);
      xfer("rr1", 1, 8'hA1, 4'b0000);
      xfer("rr2", 2, 8'hA2, 4'b0000);
      xfer("rr3", 3, 8'hA3, 4'b0000);
      xfer("rr4", 0, 8'hA0, 4'b0000);

      // Packet lock on ch1 (pointer now 0)
      req_valid = '0;
      set_ch(0, 1'b1, 8'hC0, 1'b1);
      set_ch(1, 1'b1, 8'h10, 1'b0);
      set_ch(2, 1'b1, 8'hC2, 1'b1);
      xfer("lk0", 1, 8'h10, 4'b0010);
      set_ch(1, 1'b1, 8'h11, 1'b0);
      xfer("lk1", 1, 8'h11, 4'b0010);
      set_ch(1, 1'b1, 8'h12, 1'b1);
      xfer("lk2", 1, 8'h12, 4'b0000);
      set_ch(1, 1'b0, 8'h00, 1'b0);
      xfer("lk_next", 2, 8'hC2, 4'b0000);

      // Timeout: busy never rises
      req_valid = '0;
      set_ch(3, 1'b1, 8'h7E, 1'b0);
      set_ch(0, 1'b1, 8'h01, 1'b1);
      #1;
      chk("to:ready", 8'(req_ready), 8'b1000);
      cyc();
      chk("to:wr", 8'(tx_wr), 8'd1);
      chk("to:data", tx_data, 8'h7E);
      repeat (BUSY_TO - 1) cyc();
      chk("to:err_early", 8'(err_timeout), 8'd0);
      chk("to:active_early", 8'(active), 8'd1);
      cyc();
      chk("to:err_set", 8'(err_timeout), 8'd1);
      chk("to:grant_clr", 8'(grant), 8'd0);
      chk("to:idle", 8'(active), 8'd0);
      chk("to:ch0_next", 8'(req_ready), 8'b0001);
      cyc();
      chk("to2:wr", 8'(tx_wr), 8'd1);
      chk("to2:data", tx_data, 8'h01);
      req_valid = '0;
      cyc();
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      #1;
      chk("to:err_clr", 8'(err_timeout), 8'd0);
      repeat (BUSY_TO - 3) cyc();
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("to:set_wins", 8'(err_timeout), 8'd1);
      chk("to2:idle", 8'(active), 8'd0);

      // External busy blocks acceptance
      tx_busy = 1'b1;
      set_ch(0, 1'b1, 8'h33, 1'b1);
      #1;
      chk("xb:ready0", 8'(req_ready), 8'd0);
      repeat (3) begin
         cyc();
         chk("xb:ready_hold", 8'(req_ready), 8'd0);
      end
      tx_busy = 1'b0;
      #1;
      chk("xb:ready", 8'(req_ready), 8'b0001);
      cyc();
      chk("xb:wr", 8'(tx_wr), 8'd1);
      chk("xb:data", tx_data, 8'h33);
      cyc();
      cyc();
      tx_busy = 1'b1;
      cyc();
      chk("xb:wait_done", 8'(active), 8'd1);
      chk("xb:grant", 8'(grant), 8'b0001);

      // Reset during WAIT_DONE
      #2;
      reset = 1'b1;
      #1;
      chk("mr:wr", 8'(tx_wr), 8'd0);
      chk("mr:grant", 8'(grant), 8'd0);
      chk("mr:active", 8'(active), 8'd0);
      chk("mr:ready", 8'(req_ready), 8'd0);
      chk("mr:err", 8'(err_timeout), 8'd0);
      chk("mr:data", tx_data, 8'd0);
      cyc();
      cyc();
      chk("mr:no_rewr", 8'(tx_wr), 8'd0);
      set_ch(1, 1'b1, 8'hB1, 1'b1);
      set_ch(2, 1'b1, 8'hB2, 1'b1);
      set_ch(3, 1'b1, 8'hB3, 1'b1);
      tx_busy = 1'b0;
      reset   = 1'b0;
      #1;
      chk("mr:first_ready", 8'(req_ready), 8'b0001);
      cyc();
      chk("mr:first_grant", 8'(grant), 8'b0001);
      chk("mr:first_wr", 8'(tx_wr), 8'd1);
      chk("mr:first_data", tx_data, 8'h33);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
